tone_seq_dcd: RTL

Parametrised successor to the numerically controlled tone divider in the music player (MPCD) path. It accepts notes (tone word plus duration in beats) over a valid/ready handshake and plays each note as a square wave on OSpk for the requested number of beat strobes. An articulation gap follows each note. Fully synchronous to Clk4M: the half-period tick is a clock enable, never a derived clock.

---
 rtl/tone_seq_dcd.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tone_seq_dcd.sv
// Note sequencer: plays (tone word, beat count) notes as a square wave on OSpk, then a silent gap.
// Define TONE_SEQ_DCD_OCT_EN to add the IOct octave-down prescaler.
module tone_seq_dcd #(
    parameter int unsigned TW      = 13,
    parameter int unsigned DW      = 8,
    parameter int unsigned GAP_CYC = 2000
) (
    input  logic          Clk4M,
    input  logic          RST_N,
    input  logic [TW-1:0] ITone,
    input  logic [DW-1:0] IDur,
`ifdef TONE_SEQ_DCD_OCT_EN
    input  logic [1:0]    IOct,
`endif
    input  logic          IVld,
    output logic          ORdy,
    input  logic          IBeat,
    input  logic          IAbort,
    output logic          OSpk,
    output logic          OBusy,
    output logic          ONoteEnd
);

    localparam int unsigned   GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [TW-1:0] ToneMax = {TW{1'b1}};

    typedef enum logic [1:0] {StIdle, StPlay, StGap, StEnd} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [TW-1:0] tco_q, tco_d;
    logic [DW-1:0] beat_q, beat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          spk_q, spk_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          end_q, end_d;
    logic          accept, abort, tc_tick, spk_toggle;

    assign accept  = IVld & rdy_q & ~IAbort;
    assign abort   = IAbort & ((state_q == StPlay) | (state_q == StGap));
    assign tc_tick = (state_q == StPlay) & (tone_q != ToneMax) & (tco_q == ToneMax);

    always_ff @(posedge Clk4M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (IDur == '0) ? StEnd : StPlay;
                end
            end
            StPlay: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (IBeat && (beat_q == DW'(1))) begin
                    state_d = (GAP_CYC == 0) ? StEnd : StGap;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == GW'(1)) begin
                    state_d = StEnd;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake/status flags are registered copies of the next state.
    always_comb begin
        rdy_d  = (state_d == StIdle);
        busy_d = (state_d == StPlay) | (state_d == StGap);
        end_d  = (state_d == StEnd);
    end

`ifdef TONE_SEQ_DCD_OCT_EN
    logic [1:0] oct_q, oct_d;
    logic [2:0] pre_q, pre_d;

    always_comb begin
        oct_d      = oct_q;
        pre_d      = pre_q;
        spk_toggle = 1'b0;
        if (accept) begin
            oct_d = IOct;
            pre_d = '0;
        end else if (state_d != StPlay) begin
            pre_d = '0;
        end else if (tc_tick) begin
            if (pre_q == ((3'd1 << oct_q) - 3'd1)) begin
                spk_toggle = 1'b1;
                pre_d      = '0;
            end else begin
                pre_d = pre_q + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk4M or negedge RST_N) begin
        if (!RST_N) begin
            oct_q <= '0;
            pre_q <= '0;
        end else begin
            oct_q <= oct_d;
            pre_q <= pre_d;
        end
    end
`else
    assign spk_toggle = tc_tick;
`endif

    always_comb begin
        tone_d = tone_q;
        tco_d  = tco_q;
        beat_d = beat_q;
        gap_d  = gap_q;
        spk_d  = spk_q;
        if (accept) begin
            tone_d = ITone;
            tco_d  = ITone;
            beat_d = IDur;
            spk_d  = 1'b1;
        end else if (abort) begin
            tco_d = '0;
            spk_d = 1'b1;
        end else if (state_q == StPlay) begin
            if (IBeat) begin
                beat_d = beat_q - DW'(1);
            end
            if (state_d != StPlay) begin
                spk_d = 1'b1;
                gap_d = GW'(GAP_CYC);
            end else if (tone_q != ToneMax) begin
                // Count up to all-ones, then reload: half period = 2^TW - tone.
                if (tco_q == ToneMax) begin
                    tco_d = tone_q;
                    if (spk_toggle) begin
                        spk_d = ~spk_q;
                    end
                end else begin
                    tco_d = tco_q + TW'(1);
                end
            end
        end else if (state_q == StGap) begin
            gap_d = gap_q - GW'(1);
        end
    end

    always_ff @(posedge Clk4M or negedge RST_N) begin
        if (!RST_N) begin
            tone_q <= '0;
            tco_q  <= '0;
            beat_q <= '0;
            gap_q  <= '0;
            spk_q  <= 1'b1;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            tone_q <= tone_d;
            tco_q  <= tco_d;
            beat_q <= beat_d;
            gap_q  <= gap_d;
            spk_q  <= spk_d;
            rdy_q  <= rdy_d;
            busy_q <= busy_d;
            end_q  <= end_d;
        end
    end

    assign OSpk     = spk_q;
    assign ORdy     = rdy_q;
    assign OBusy    = busy_q;
    assign ONoteEnd = end_q;

endmodule
